// File: rtl/freq_bcd_format_if.sv
// Bus between the frequency counter, the BCD formatter and the
// seven-segment driver: count strobe in, formatted display word out.
interface freq_bcd_format_if;
    logic [31:0] i_count;
    logic        i_count_valid;
    logic [31:0] o_data;
    logic [2:0]  o_dp_pos;
    logic [1:0]  o_range;
    logic        o_busy;
    logic        o_done;
    logic        o_lost;

    modport master (
        output i_count,
        output i_count_valid,
        input  o_data,
        input  o_dp_pos,
        input  o_range,
        input  o_busy,
        input  o_done,
        input  o_lost
    );

    modport slave (
        input  i_count,
        input  i_count_valid,
        output o_data,
        output o_dp_pos,
        output o_range,
        output o_busy,
        output o_done,
        output o_lost
    );
endinterface

// File: rtl/freq_bcd_format.sv
// Sequential binary-to-BCD formatter: one-bit-per-cycle double-dabble of a
// 32-bit Hz count into 10 BCD digits, then auto-ranged into an 8-digit
// window with decimal-point position and leading-zero blanking.
module freq_bcd_format #(
    parameter logic [3:0] p_blank_code = 4'hA,
    parameter bit         p_blank_en   = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    freq_bcd_format_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_FMT  = 2'd2
    } state_t;

    // Value shown after reset: a lone "0" (or all zeros without blanking).
    localparam logic [31:0] c_rst_data = p_blank_en ? {{7{p_blank_code}}, 4'h0} : 32'h0000_0000;

    // Double-dabble correction: every digit >= 5 gets +3 before the shift.
    function automatic logic [39:0] dabble_adj(input logic [39:0] a);
        logic [39:0] r;
        r = a;
        for (int i = 0; i < 10; i++) begin
            if (a[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = a[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = a[4*i +: 4];
            end
        end
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [31:0] sh_q, sh_d;
    logic [39:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] data_q, data_d;
    logic [2:0]  dp_q, dp_d;
    logic [1:0]  range_q, range_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        lost_q, lost_d;

    logic [39:0] adj_s;
    logic [1:0]  shift_s;
    logic [31:0] win_s;
    logic [31:0] fmt_data_s;
    logic [2:0]  fmt_dp_s;
    logic        nz_seen_s;

    assign adj_s = dabble_adj(acc_q);

    // Range selection, window extraction and leading-zero blanking of the finished BCD value.
    always_comb begin
        shift_s    = 2'd0;
        win_s      = acc_q[31:0];
        fmt_dp_s   = 3'd0;
        nz_seen_s  = 1'b0;
        fmt_data_s = 32'h0000_0000;
        if (acc_q[39:36] != 4'd0) begin
            shift_s = 2'd2;
        end else if (acc_q[35:32] != 4'd0) begin
            shift_s = 2'd1;
        end else begin
            shift_s = 2'd0;
        end
        case (shift_s)
            2'd0:    begin win_s = acc_q[31:0];  fmt_dp_s = 3'd0; end
            2'd1:    begin win_s = acc_q[35:4];  fmt_dp_s = 3'd5; end
            2'd2:    begin win_s = acc_q[39:8];  fmt_dp_s = 3'd4; end
            default: begin win_s = acc_q[31:0];  fmt_dp_s = 3'd0; end
        endcase
        fmt_data_s = win_s;
        // Scan from the top digit down; digit 0 is never blanked.
        for (int i = 7; i >= 1; i--) begin
            if (win_s[4*i +: 4] != 4'd0) begin
                nz_seen_s = 1'b1;
            end else begin
                nz_seen_s = nz_seen_s;
            end
            if (!nz_seen_s && (shift_s == 2'd0) && p_blank_en) begin
                fmt_data_s[4*i +: 4] = p_blank_code;
            end else begin
                fmt_data_s[4*i +: 4] = win_s[4*i +: 4];
            end
        end
    end

    // Next-state logic of the IDLE/CONV/FMT sequencer and its datapath.
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        dp_d    = dp_q;
        range_d = range_q;
        done_d  = 1'b0;
        lost_d  = bus.i_count_valid && (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (bus.i_count_valid) begin
                    sh_d    = bus.i_count;
                    acc_d   = 40'd0;
                    cnt_d   = 5'd0;
                    state_d = ST_CONV;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CONV: begin
                acc_d = {adj_s[38:0], sh_q[31]};
                sh_d  = {sh_q[30:0], 1'b0};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = ST_FMT;
                end else begin
                    state_d = ST_CONV;
                end
            end
            ST_FMT: begin
                // All three result fields change on the same edge.
                data_d  = fmt_data_s;
                dp_d    = fmt_dp_s;
                range_d = shift_s;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sh_q    <= 32'h0000_0000;
            acc_q   <= 40'd0;
            cnt_q   <= 5'd0;
            data_q  <= c_rst_data;
            dp_q    <= 3'd0;
            range_q <= 2'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            dp_q    <= dp_d;
            range_q <= range_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            lost_q  <= lost_d;
        end
    end

    assign bus.o_data   = data_q;
    assign bus.o_dp_pos = dp_q;
    assign bus.o_range  = range_q;
    assign bus.o_busy   = busy_q;
    assign bus.o_done   = done_q;
    assign bus.o_lost   = lost_q;

endmodule

// File: tb/tb_freq_bcd_format.sv
// Self-checking bench for freq_bcd_format: table vectors, random counts
// against an arithmetic reference model, and hand-written corner sequences.
module tb_freq_bcd_format;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    freq_bcd_format_if ifa ();
    freq_bcd_format_if ifb ();

    freq_bcd_format #(.p_blank_code(4'hA), .p_blank_en(1'b1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    freq_bcd_format #(.p_blank_code(4'hA), .p_blank_en(1'b0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] cnt;
        logic [31:0] data;
        logic [2:0]  dp;
        logic [1:0]  rg;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: decimal arithmetic on the count, no BCD shifting.
    task automatic model(input logic [31:0] c, input bit ben,
                         output logic [31:0] d, output logic [2:0] dp, output logic [1:0] rg);
        longint unsigned v;
        longint unsigned w;
        int ndig;
        int wdig;
        int s;
        v = c;
        ndig = 1;
        w = v;
        while (w >= 10) begin
            w = w / 10;
            ndig++;
        end
        s = (ndig > 8) ? ndig - 8 : 0;
        w = v;
        for (int i = 0; i < s; i++) w = w / 10;
        wdig = (s == 0) ? ndig : 8;
        d = 32'h0;
        for (int i = 0; i < 8; i++) begin
            if (ben && s == 0 && i >= wdig) d[4*i +: 4] = 4'hA;
            else d[4*i +: 4] = 4'(w % 10);
            w = w / 10;
        end
        rg = 2'(s);
        dp = (s == 0) ? 3'd0 : (s == 1) ? 3'd5 : 3'd4;
    endtask

    task automatic start(input logic [31:0] c);
        @(negedge clk);
        ifa.i_count       = c;
        ifa.i_count_valid = 1'b1;
        @(negedge clk);
        ifa.i_count_valid = 1'b0;
        ifa.i_count       = $urandom;
    endtask

    task automatic wait_done(input int k0, output int lat);
        lat = -1;
        for (int k = k0 + 1; k <= 40; k++) begin
            @(negedge clk);
            if (ifa.o_done) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[9];
        int          lat;
        int          ndone;
        logic [31:0] c;
        logic [31:0] ed;
        logic [2:0]  edp;
        logic [1:0]  erg;

        tbl[0] = '{32'd0,          32'hAAAA_AAA0, 3'd0, 2'd0};
        tbl[1] = '{32'd100,        32'hAAAA_A100, 3'd0, 2'd0};
        tbl[2] = '{32'd12345678,   32'h1234_5678, 3'd0, 2'd0};
        tbl[3] = '{32'd99999999,   32'h9999_9999, 3'd0, 2'd0};
        tbl[4] = '{32'd123456789,  32'h1234_5678, 3'd5, 2'd1};
        tbl[5] = '{32'd100000000,  32'h1000_0000, 3'd5, 2'd1};
        tbl[6] = '{32'd4294967295, 32'h4294_9672, 3'd4, 2'd2};
        tbl[7] = '{32'd1000000000, 32'h1000_0000, 3'd4, 2'd2};
        tbl[8] = '{32'd7,          32'hAAAA_AAA7, 3'd0, 2'd0};

        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        ifa.i_count = 32'h0; ifa.i_count_valid = 1'b0;
        ifb.i_count = 32'h0; ifb.i_count_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("reset data",   ifa.o_data, 32'hAAAA_AAA0);
        check("reset dp",     32'(ifa.o_dp_pos), 32'd0);
        check("reset range",  32'(ifa.o_range), 32'd0);
        check("reset busy",   32'(ifa.o_busy), 32'd0);
        check("reset done",   32'(ifa.o_done), 32'd0);
        check("reset lost",   32'(ifa.o_lost), 32'd0);
        check("reset data noblank", ifb.o_data, 32'h0);

        // Table vectors, latency checked on each.
        for (int i = 0; i < 9; i++) begin
            start(tbl[i].cnt);
            check("busy after accept", 32'(ifa.o_busy), 32'd1);
            wait_done(0, lat);
            check("latency", 32'(lat), 32'd33);
            check("tbl data",  ifa.o_data, tbl[i].data);
            check("tbl dp",    32'(ifa.o_dp_pos), 32'(tbl[i].dp));
            check("tbl range", 32'(ifa.o_range), 32'(tbl[i].rg));
            @(negedge clk);
            check("done one cycle", 32'(ifa.o_done), 32'd0);
            check("busy idle", 32'(ifa.o_busy), 32'd0);
        end

        // Outputs hold between conversions.
        repeat (5) @(negedge clk);
        check("hold data", ifa.o_data, tbl[8].data);

        // Random counts across magnitudes against the model.
        for (int i = 0; i < 30; i++) begin
            c = $urandom >> $urandom_range(0, 31);
            model(c, 1'b1, ed, edp, erg);
            start(c);
            wait_done(0, lat);
            check("rand latency", 32'(lat), 32'd33);
            check("rand data",  ifa.o_data, ed);
            check("rand dp",    32'(ifa.o_dp_pos), 32'(edp));
            check("rand range", 32'(ifa.o_range), 32'(erg));
        end

        // Strobe while busy is dropped and flagged; next strobe at T+34 accepted.
        start(32'd5);
        repeat (9) @(negedge clk);
        ifa.i_count = 32'd7;
        ifa.i_count_valid = 1'b1;
        @(negedge clk);
        ifa.i_count_valid = 1'b0;
        check("lost pulse", 32'(ifa.o_lost), 32'd1);
        @(negedge clk);
        check("lost one cycle", 32'(ifa.o_lost), 32'd0);
        wait_done(11, lat);
        check("lost latency", 32'(lat), 32'd33);
        check("lost data", ifa.o_data, 32'hAAAA_AAA5);
        ifa.i_count = 32'd9;
        ifa.i_count_valid = 1'b1;
        @(negedge clk);
        ifa.i_count_valid = 1'b0;
        check("T+34 accepted busy", 32'(ifa.o_busy), 32'd1);
        check("T+34 not lost", 32'(ifa.o_lost), 32'd0);
        wait_done(0, lat);
        check("T+34 latency", 32'(lat), 32'd33);
        check("T+34 data", ifa.o_data, 32'hAAAA_AAA9);

        // Reset mid-conversion: immediate reset values, no completion.
        start(32'd123456789);
        repeat (15) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort data",  ifa.o_data, 32'hAAAA_AAA0);
        check("abort dp",    32'(ifa.o_dp_pos), 32'd0);
        check("abort range", 32'(ifa.o_range), 32'd0);
        check("abort busy",  32'(ifa.o_busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ifa.o_done) ndone++;
        end
        check("abort no done", 32'(ndone), 32'd0);
        check("abort data kept", ifa.o_data, 32'hAAAA_AAA0);

        // No-blanking instance.
        @(negedge clk);
        ifb.i_count = 32'd42;
        ifb.i_count_valid = 1'b1;
        @(negedge clk);
        ifb.i_count_valid = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (ifb.o_done) begin
                lat = k;
                break;
            end
        end
        check("noblank latency", 32'(lat), 32'd33);
        check("noblank data", ifb.o_data, 32'h0000_0042);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
